// File: rtl/tl_controller.sv
// Fixed-time traffic-light controller for a NS/EW crossing with pedestrian lamps.
// Single Moore FSM. A down-counter sets how long each phase lasts; lamps are registered with the state.
//
// state | meaning
// NS_G  | NS vehicles green, NS pedestrians walk
// NS_Y  | NS vehicles yellow, NS pedestrians clearance
// RED_A | all-red clearance before EW is released
// EW_G  | EW vehicles green, EW pedestrians walk
// EW_Y  | EW vehicles yellow, EW pedestrians clearance
// RED_B | all-red clearance before NS is released (also the reset state)

module tl_controller #(
   parameter int T_GREEN  = 8,
   parameter int T_YELLOW = 3,
   parameter int T_ALLRED = 1
) (
   input  logic       clk,
   input  logic       res,
   output logic [2:0] NS,
   output logic [2:0] EW,
   output logic [2:0] P_NS,
   output logic [2:0] P_EW
);

   typedef enum logic [2:0] {
      NS_G  = 3'd0,
      NS_Y  = 3'd1,
      RED_A = 3'd2,
      EW_G  = 3'd3,
      EW_Y  = 3'd4,
      RED_B = 3'd5
   } state_t;

   localparam logic [7:0] LD_GREEN  = 8'(T_GREEN - 1);
   localparam logic [7:0] LD_YELLOW = 8'(T_YELLOW - 1);
   localparam logic [7:0] LD_ALLRED = 8'(T_ALLRED - 1);

   localparam logic [2:0] LAMP_RED    = 3'b100;
   localparam logic [2:0] LAMP_YELLOW = 3'b010;
   localparam logic [2:0] LAMP_GREEN  = 3'b001;

   state_t     state;
   logic [7:0] cnt;

   function automatic state_t next_of(input state_t s);
      case (s)
         NS_G:    next_of = NS_Y;
         NS_Y:    next_of = RED_A;
         RED_A:   next_of = EW_G;
         EW_G:    next_of = EW_Y;
         EW_Y:    next_of = RED_B;
         RED_B:   next_of = NS_G;
         default: next_of = RED_B;
      endcase
   endfunction

   function automatic logic [7:0] load_of(input state_t s);
      case (s)
         NS_G, EW_G: load_of = LD_GREEN;
         NS_Y, EW_Y: load_of = LD_YELLOW;
         default:    load_of = LD_ALLRED;
      endcase
   endfunction

   // Lamp word ordered {NS, EW, P_NS, P_EW}; pedestrian lamps share the vehicle encoding.
   function automatic logic [11:0] lamps_of(input state_t s);
      case (s)
         NS_G:    lamps_of = {LAMP_GREEN,  LAMP_RED,    LAMP_GREEN,  LAMP_RED};
         NS_Y:    lamps_of = {LAMP_YELLOW, LAMP_RED,    LAMP_YELLOW, LAMP_RED};
         EW_G:    lamps_of = {LAMP_RED,    LAMP_GREEN,  LAMP_RED,    LAMP_GREEN};
         EW_Y:    lamps_of = {LAMP_RED,    LAMP_YELLOW, LAMP_RED,    LAMP_YELLOW};
         default: lamps_of = {LAMP_RED,    LAMP_RED,    LAMP_RED,    LAMP_RED};
      endcase
   endfunction

   function automatic logic legal(input state_t s);
      case (s)
         NS_G, NS_Y, RED_A, EW_G, EW_Y, RED_B: legal = 1'b1;
         default:                              legal = 1'b0;
      endcase
   endfunction

   // An illegal encoding advances immediately so it never waits out a stale count.
   always_ff @(posedge clk) begin
      if (!res) begin
         state                 <= RED_B;
         cnt                   <= LD_ALLRED;
         {NS, EW, P_NS, P_EW}  <= lamps_of(RED_B);
      end else if (cnt == 8'd0 || !legal(state)) begin
         state                 <= next_of(state);
         cnt                   <= load_of(next_of(state));
         {NS, EW, P_NS, P_EW}  <= lamps_of(next_of(state));
      end else begin
         cnt                   <= cnt - 8'd1;
      end
   end

endmodule

// File: tb/tb_tl_controller.sv
// Scoreboard bench for tl_controller: default timing and a short override (2/1/2) run side by side.
// A phase-position model predicts the lamps; a negedge monitor pops and compares.

module tb_tl_controller;

   localparam int GA = 8, YA = 3, RA = 1;
   localparam int GB = 2, YB = 1, RB = 2;
   localparam int PA = 2 * (GA + YA + RA);
   localparam int PB = 2 * (GB + YB + RB);

   logic       clk = 1'b0;
   logic       res = 1'b0;
   logic [2:0] ns_a, ew_a, pns_a, pew_a;
   logic [2:0] ns_b, ew_b, pns_b, pew_b;

   typedef struct packed {
      logic [11:0] a;
      logic [11:0] b;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   p_a = 0;
   int   p_b = 0;
   bit   seen_reset = 1'b0;

   always #5 clk = ~clk;

   tl_controller dut_a (
      .clk (clk), .res (res),
      .NS  (ns_a), .EW (ew_a), .P_NS (pns_a), .P_EW (pew_a)
   );

   tl_controller #(.T_GREEN(GB), .T_YELLOW(YB), .T_ALLRED(RB)) dut_b (
      .clk (clk), .res (res),
      .NS  (ns_b), .EW (ew_b), .P_NS (pns_b), .P_EW (pew_b)
   );

   // Position p counts cycles from the start of NS green within one full period.
   function automatic logic [11:0] ref_lamps(input int p, input int g, input int y, input int r);
      if (p < g)                 return 12'b001_100_001_100;
      else if (p < g + y)        return 12'b010_100_010_100;
      else if (p < g + y + r)    return 12'b100_100_100_100;
      else if (p < 2*g + y + r)  return 12'b100_001_100_001;
      else if (p < 2*g + 2*y + r) return 12'b100_010_100_010;
      else                       return 12'b100_100_100_100;
   endfunction

   task automatic step(input logic r);
      exp_t e;
      @(negedge clk);
      res = r;
      @(posedge clk);
      #1;
      if (r == 1'b0) begin
         p_a = PA - RA;
         p_b = PB - RB;
         seen_reset = 1'b1;
      end else begin
         p_a = (p_a + 1) % PA;
         p_b = (p_b + 1) % PB;
      end
      if (seen_reset) begin
         e.a = ref_lamps(p_a, GA, YA, RA);
         e.b = ref_lamps(p_b, GB, YB, RB);
         q.push_back(e);
      end
   endtask

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp_v);
      logic [2:0] ns, ew, pns, pew;
      {ns, ew, pns, pew} = act;
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s lamps actual=%b expected=%b (p_a=%0d p_b=%0d t=%0t)",
                  name, act, exp_v, p_a, p_b, $time);
      end
      n_tests++;
      if (!($onehot(ns) && $onehot(ew) && $onehot(pns) && $onehot(pew))) begin
         n_fail++;
         $display("FAIL %s onehot actual=%b required=each field one-hot", name, act);
      end
      n_tests++;
      if (ns !== 3'b100 && ew !== 3'b100) begin
         n_fail++;
         $display("FAIL %s safety actual NS=%b EW=%b required=one of them red", name, ns, ew);
      end
      n_tests++;
      if (pns !== ns || pew !== ew) begin
         n_fail++;
         $display("FAIL %s ped_track actual P_NS=%b P_EW=%b required=%b %b", name, pns, pew, ns, ew);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("dut_a", {ns_a, ew_a, pns_a, pew_a}, e.a);
            check("dut_b", {ns_b, ew_b, pns_b, pew_b}, e.b);
         end
      end
   end

   initial begin
      int guard;
      step(1'b0);
      step(1'b0);
      for (int i = 0; i < 50; i++) step(1'b1);

      // Pulse reset for one edge while the default instance is in EW green.
      guard = 0;
      while (!(p_a >= GA + YA + RA && p_a < 2*GA + YA + RA) && guard < 2*PA) begin
         step(1'b1);
         guard++;
      end
      n_tests++;
      if (guard >= 2*PA) begin
         n_fail++;
         $display("FAIL reach_ew_g actual=timeout required=EW_G within %0d cycles", 2*PA);
      end
      step(1'b0);
      for (int i = 0; i < 30; i++) step(1'b1);

      for (int i = 0; i < 600; i++)
         step(($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1);

      @(negedge clk);
      @(negedge clk);
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain actual=%0d entries required=0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tl_controller.md
Name: tl_controller

Overview:
- Fixed-time four-way traffic-light controller for one crossing with a North-South (NS) road and an East-West (EW) road.
- Drives vehicle lamps and pedestrian lamps for both directions from a single Moore FSM with a cycle down-counter.
- Stand-alone leaf block: no handshake, free-running after reset release.

Parameters:
- T_GREEN, 8, cycles each vehicle green phase lasts (1..256)
- T_YELLOW, 3, cycles each vehicle yellow phase lasts (1..256)
- T_ALLRED, 1, cycles of all-red clearance between directions (1..256)

Ports:
- clk  input  1  system clock; all state changes on rising edge
- res  input  1  synchronous active-low reset; res=0 sampled at a rising edge resets the block
- NS  output  3  NS vehicle lamp, one-hot {red,yellow,green} = bit2,bit1,bit0
- EW  output  3  EW vehicle lamp, same encoding
- P_NS  output  3  pedestrian lamp for walkers moving parallel to NS traffic, one-hot {dont_walk, clearance, walk} = bit2,bit1,bit0
- P_EW  output  3  pedestrian lamp parallel to EW traffic, same encoding

Behaviour:
- One clock; reset is synchronous and active-low (clk, res).
- States and outputs, listed as NS / EW / P_NS / P_EW:
  - NS_G: 001 / 100 / 001 / 100
  - NS_Y: 010 / 100 / 010 / 100
  - RED_A: 100 / 100 / 100 / 100
  - EW_G: 100 / 001 / 100 / 001
  - EW_Y: 100 / 010 / 100 / 010
  - RED_B: 100 / 100 / 100 / 100
- Sequence: NS_G -> NS_Y -> RED_A -> EW_G -> EW_Y -> RED_B -> NS_G, repeating forever.
- Outputs are pure decodes of the registered state (Moore).
- Every output is always exactly one-hot; 000 and multi-hot values never appear.
- Timer: 8-bit down-counter `cnt`.
  - On entering a state, `cnt` is loaded with that state's duration minus 1.
  - Each rising edge with `cnt` != 0 decrements it.
  - The rising edge with `cnt` == 0 advances the state and reloads `cnt`.
  - Each state therefore lasts exactly its parameter in cycles.
  - Full period = 2*(T_GREEN+T_YELLOW+T_ALLRED) = 24 cycles at the defaults.
- Reset: any rising edge with res=0 forces state=RED_B and cnt=T_ALLRED-1, regardless of the current state or count.
  - All four outputs are 100 from the first reset edge onward.
  - After release, RED_B runs its normal T_ALLRED cycles, then NS_G.
  - With defaults, the first rising edge with res=1 moves the block to NS_G.
- Reset mid-operation behaves identically; no partial phase is resumed.
- Safety invariant: NS and EW are never both non-red. P_NS walk/clearance only coincides with NS non-red; likewise P_EW with EW.
- Illegal or unreachable state encodings recover to RED_B on the next edge (default branch).
- Before the first reset edge, outputs are undefined; the bench must reset first.

Test Plan:
- Hold res=0 for 2 edges -> NS=EW=P_NS=P_EW=100 after the first reset edge; stays while res=0.
- Release res at edge E0 (defaults):
  - edges E0..E0+7: NS=001, P_NS=001, EW=100, P_EW=100
  - E0+8..E0+10: NS=010, P_NS=010
  - E0+11: all 100
  - E0+12..E0+19: EW=001, P_EW=001
  - E0+20..E0+22: EW=010, P_EW=010
  - E0+23: all 100
  - E0+24: NS=001 again (period 24)
- Assert res=0 for one edge during EW_G, then release -> all outputs 100 at that edge, NS=001 on the next edge, then normal timing resumes from NS_G.
- Run 48+ cycles checking every cycle -> each output one-hot; never NS!=100 and EW!=100 simultaneously; P_x tracks x.
- Override T_GREEN=2, T_YELLOW=1, T_ALLRED=2 -> after release: RED_B 2 cycles, NS_G 2, NS_Y 1, RED_A 2, EW_G 2, EW_Y 1; period 10.
